matmul_tile_ctrl: RTL and testbench

Top-level sequencer for the 8x8 matrix-multiply datapath. It computes C in 2x2 output tiles and drives the address generator's `Load` and restart. It also emits MAC enable and accumulator-clear strobes aligned to memory read latency, and writes the four accumulated results of each tile into C memory. It sits between the host start/done handshake and the address-generator, operand RAM, MAC and C-RAM datapath.

---
 rtl/matmul_tile_ctrl.sv | 140 ++++++++++++++
 tb/tb_matmul_tile_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_ctrl.sv
// rtl/matmul_tile_ctrl.sv - 2x2-tile sequencer for the NxN matrix-multiply datapath
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             begin a full multiply (sampled only in IDLE)
//   busy, done        host handshake: busy outside IDLE, done pulses in the final cycle
//   agen_rst          restart pulse to the address generator (tile 0, k=0)
//   agen_load         address generator Load, one k-step per high cycle
//   acc_clr           clear the four tile accumulators
//   mac_en            operands valid, accumulate (agen_load delayed by 1+RD_LAT)
//   c_we, c_sel       C RAM write enable and result select (0..3 within the tile)
//   c_addr            C write address, row*N+col
//   tile_i, tile_j    current tile origin (even values)
module matmul_tile_ctrl #(
    parameter int N       = 8,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1,
    parameter int AW      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 agen_rst,
    output logic                 agen_load,
    output logic                 acc_clr,
    output logic                 mac_en,
    output logic                 c_we,
    output logic [1:0]           c_sel,
    output logic [AW-1:0]        c_addr,
    output logic [$clog2(N)-1:0] tile_i,
    output logic [$clog2(N)-1:0] tile_j
);

    localparam int TW = $clog2(N);
    // Drain covers the generator's address register, RAM read latency and the MAC update.
    localparam int D  = 1 + RD_LAT + MAC_LAT;
    localparam int CW = $clog2(N + D + 4) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CLR, S_ISSUE, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [TW-1:0]   ti_nx, tj_nx;
    logic [1:0]      sel_nx;
    logic [TW-1:0]   row_nx, col_nx;
    logic [AW-1:0]   addr_nx;
    logic [RD_LAT:0] load_pipe;

    // mac_en is the tail of a 1+RD_LAT stage delay line fed by agen_load.
    assign mac_en = load_pipe[RD_LAT];

    always_comb begin
        state_nx = state;
        ti_nx    = tile_i;
        tj_nx    = tile_j;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_INIT;
                    ti_nx    = '0;
                    tj_nx    = '0;
                end
            end
            S_INIT:  state_nx = S_CLR;
            S_CLR:   state_nx = S_ISSUE;
            S_ISSUE: if (cnt == CW'(N - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (cnt == CW'(D - 1)) state_nx = S_WRITE;
            S_WRITE: begin
                if (cnt == CW'(3)) begin
                    if (tile_j < TW'(N - 2)) begin
                        tj_nx    = tile_j + TW'(2);
                        state_nx = S_CLR;
                    end else if (tile_i < TW'(N - 2)) begin
                        tj_nx    = '0;
                        ti_nx    = tile_i + TW'(2);
                        state_nx = S_CLR;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Counter restarts on every state change and only runs in the timed states.
        cnt_nx = '0;
        if (state_nx == state &&
            (state == S_ISSUE || state == S_DRAIN || state == S_WRITE)) begin
            cnt_nx = cnt + CW'(1);
        end

        sel_nx  = (state_nx == S_WRITE) ? cnt_nx[1:0] : 2'd0;
        row_nx  = ti_nx + TW'(sel_nx[1]);
        col_nx  = tj_nx + TW'(sel_nx[0]);
        addr_nx = AW'(row_nx) * AW'(N) + AW'(col_nx);
    end

    // Outputs are registered decodes of the next state, so each strobe is
    // high exactly during the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tile_i    <= '0;
            tile_j    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            agen_rst  <= 1'b0;
            agen_load <= 1'b0;
            acc_clr   <= 1'b0;
            c_we      <= 1'b0;
            c_sel     <= 2'd0;
            c_addr    <= '0;
            load_pipe <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tile_i    <= ti_nx;
            tile_j    <= tj_nx;
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_DONE);
            agen_rst  <= (state_nx == S_INIT);
            agen_load <= (state_nx == S_ISSUE);
            acc_clr   <= (state_nx == S_CLR);
            c_we      <= (state_nx == S_WRITE);
            c_sel     <= sel_nx;
            c_addr    <= (state_nx == S_WRITE) ? addr_nx : '0;
            load_pipe[0] <= agen_load;
            for (int s = 1; s <= RD_LAT; s++) begin
                load_pipe[s] <= load_pipe[s-1];
            end
        end
    end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// tb/tb_matmul_tile_ctrl.sv - directed self-checking bench for matmul_tile_ctrl
module tb_matmul_tile_ctrl;

    logic clk = 1'b0;
    logic reset, start;
    always #5 clk = ~clk;

    logic       busy_a, done_a, agen_rst_a, agen_load_a, acc_clr_a, mac_en_a, c_we_a;
    logic [1:0] c_sel_a;
    logic [5:0] c_addr_a;
    logic [2:0] tile_i_a, tile_j_a;
    logic       busy_b, done_b, agen_rst_b, agen_load_b, acc_clr_b, mac_en_b, c_we_b;
    logic [1:0] c_sel_b;
    logic [5:0] c_addr_b;
    logic [2:0] tile_i_b, tile_j_b;

    matmul_tile_ctrl #(.N(8), .RD_LAT(1), .MAC_LAT(1), .AW(6)) dut_a (
        .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
        .agen_rst(agen_rst_a), .agen_load(agen_load_a), .acc_clr(acc_clr_a),
        .mac_en(mac_en_a), .c_we(c_we_a), .c_sel(c_sel_a), .c_addr(c_addr_a),
        .tile_i(tile_i_a), .tile_j(tile_j_a)
    );

    matmul_tile_ctrl #(.N(8), .RD_LAT(2), .MAC_LAT(1), .AW(6)) dut_b (
        .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
        .agen_rst(agen_rst_b), .agen_load(agen_load_b), .acc_clr(acc_clr_b),
        .mac_en(mac_en_b), .c_we(c_we_b), .c_sel(c_sel_b), .c_addr(c_addr_b),
        .tile_i(tile_i_b), .tile_j(tile_j_b)
    );

    int checks = 0;
    int failures = 0;

    int n_busy_a, n_mac_a, n_clr_a, n_we_a, n_done_a, done_pos_a, rst_first_a;
    int load1_a, mac1_a, last_mac_a, gap_bad_a, sel_bad_a, ovl_a;
    int n_busy_b, n_mac_b, load1_b, mac1_b;
    int addr_log[64];
    bit ok;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int outs_a();
        return int'({busy_a, done_a, agen_rst_a, agen_load_a, acc_clr_a, mac_en_a,
                     c_we_a, c_sel_a, c_addr_a, tile_i_a, tile_j_a});
    endfunction

    function automatic int outs_b();
        return int'({busy_b, done_b, agen_rst_b, agen_load_b, acc_clr_b, mac_en_b,
                     c_we_b, c_sel_b, c_addr_b, tile_i_b, tile_j_b});
    endfunction

    // One start pulse, then observe both DUTs until both drop busy.
    // A second start pulse is injected at cycle pulse_at (0 = none).
    task automatic run(input int pulse_at, output bit done_ok);
        n_busy_a = 0; n_mac_a = 0; n_clr_a = 0; n_we_a = 0; n_done_a = 0;
        done_pos_a = -1; rst_first_a = 0; load1_a = -1; mac1_a = -1;
        last_mac_a = -100; gap_bad_a = 0; sel_bad_a = 0; ovl_a = 0;
        n_busy_b = 0; n_mac_b = 0; load1_b = -1; mac1_b = -1;
        for (int i = 0; i < 64; i++) addr_log[i] = -1;
        done_ok = 0;
        start = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            tick;
            if (c == 1) start = 1'b0;
            if (pulse_at != 0 && c == pulse_at) start = 1'b1;
            if (pulse_at != 0 && c == pulse_at + 1) start = 1'b0;
            if (busy_a) begin
                n_busy_a++;
                if (n_busy_a == 1) rst_first_a = int'(agen_rst_a);
            end
            if (done_a) begin
                n_done_a++;
                done_pos_a = n_busy_a;
            end
            if (agen_load_a && load1_a < 0) load1_a = c;
            if (mac_en_a) begin
                n_mac_a++;
                last_mac_a = c;
                if (mac1_a < 0) mac1_a = c;
                if (acc_clr_a || c_we_a) ovl_a++;
            end
            if (acc_clr_a) n_clr_a++;
            if (c_we_a) begin
                if (n_we_a % 4 == 0 && c - last_mac_a != 2) gap_bad_a++;
                if (int'(c_sel_a) != n_we_a % 4) sel_bad_a++;
                if (n_we_a < 64) addr_log[n_we_a] = int'(c_addr_a);
                n_we_a++;
            end
            if (busy_b) n_busy_b++;
            if (agen_load_b && load1_b < 0) load1_b = c;
            if (mac_en_b) begin
                n_mac_b++;
                if (mac1_b < 0) mac1_b = c;
            end
            if (c > 1 && !busy_a && !busy_b) begin
                done_ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int n, got, rsts, ti, tj;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick;
        reset = 1'b0;

        // Idle after reset with start low.
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("idle_outs_a", outs_a(), 0);
        end
        chk("idle_outs_b", outs_b(), 0);

        // Full run with a stray start pulse during the first ISSUE.
        run(5, ok);
        chk("run1_complete", int'(ok), 1);
        chk("run1_busy_a", n_busy_a, 258);
        chk("run1_done_cnt", n_done_a, 1);
        chk("run1_done_pos", done_pos_a, 258);
        chk("run1_agen_rst_first", rst_first_a, 1);
        chk("run1_mac_cnt", n_mac_a, 128);
        chk("run1_clr_cnt", n_clr_a, 16);
        chk("run1_we_cnt", n_we_a, 64);
        chk("run1_mac_lead", mac1_a - load1_a, 2);
        chk("run1_mac_to_we_gap", gap_bad_a, 0);
        chk("run1_sel_order", sel_bad_a, 0);
        chk("run1_mac_in_clr_write", ovl_a, 0);
        chk("tile0_addr0", addr_log[0], 0);
        chk("tile0_addr1", addr_log[1], 1);
        chk("tile0_addr2", addr_log[2], 8);
        chk("tile0_addr3", addr_log[3], 9);
        chk("tile1_addr0", addr_log[4], 2);
        chk("tile1_addr3", addr_log[7], 11);
        chk("tile4_addr0", addr_log[16], 16);
        chk("tile4_addr1", addr_log[17], 17);
        chk("tile4_addr2", addr_log[18], 24);
        chk("tile4_addr3", addr_log[19], 25);
        chk("tile15_addr0", addr_log[60], 54);
        chk("tile15_addr1", addr_log[61], 55);
        chk("tile15_addr2", addr_log[62], 62);
        chk("tile15_addr3", addr_log[63], 63);
        for (int w = 0; w < 64; w++) begin
            ti = 2 * ((w / 4) / 4);
            tj = 2 * ((w / 4) % 4);
            chk($sformatf("addr_w%0d", w), addr_log[w], (ti + (w % 4) / 2) * 8 + tj + (w % 2));
        end
        chk("tile_i_hold", int'(tile_i_a), 6);
        chk("tile_j_hold", int'(tile_j_a), 6);
        chk("rd2_busy", n_busy_b, 274);
        chk("rd2_mac_cnt", n_mac_b, 128);
        chk("rd2_mac_lead", mac1_b - load1_b, 3);

        // Start held high: one run, then IDLE for one cycle, then a new INIT.
        start = 1'b1;
        n = 0; got = 0; rsts = 0;
        for (int c = 0; c < 400; c++) begin
            tick;
            if (busy_a) n++;
            if (agen_rst_a) rsts++;
            if (done_a) begin
                got = 1;
                break;
            end
        end
        chk("hold_done_seen", got, 1);
        chk("hold_busy", n, 258);
        chk("hold_single_rst", rsts, 1);
        tick;
        chk("hold_idle_gap", int'(busy_a), 0);
        tick;
        chk("hold_reinit_rst", int'(agen_rst_a), 1);
        chk("hold_reinit_busy", int'(busy_a), 1);
        start = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("hold_reset_outs", outs_a(), 0);

        // Reset during the third tile's ISSUE.
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (36) tick;
        chk("mid_in_issue", int'(agen_load_a), 1);
        chk("mid_tile_j", int'(tile_j_a), 4);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_reset_outs_a", outs_a(), 0);
        chk("mid_reset_outs_b", outs_b(), 0);
        repeat (3) tick;
        chk("mid_stays_idle", outs_a(), 0);

        run(0, ok);
        chk("run2_complete", int'(ok), 1);
        chk("run2_busy_a", n_busy_a, 258);
        chk("run2_agen_rst_first", rst_first_a, 1);
        chk("run2_we_cnt", n_we_a, 64);
        chk("run2_mac_cnt", n_mac_a, 128);
        chk("run2_busy_b", n_busy_b, 274);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
